// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, RX FSM
// state encodings and the bit-timer width helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_BRKWAIT = 3'd5
  } rx_state_t;

  function automatic int cnt_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, free-running bit timer and 3-sample majority voter.
// The owner clears the timer on a detected start edge to align bit periods.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int clksPerBit = 234
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_serial,
  input  logic i_cntClear,
  output logic o_s,
  output logic o_bitStrobe,
  output logic o_bit
);

  localparam int W = cnt_width(clksPerBit);
  localparam int H = clksPerBit / 2;
  localparam logic [W-1:0] CNT_LAST = W'(clksPerBit - 1);
  localparam logic [W-1:0] CNT_SA   = W'(H - 1);
  localparam logic [W-1:0] CNT_SB   = W'(H);
  localparam logic [W-1:0] CNT_DEC  = W'(H + 1);

  logic         r_sync1;
  logic         r_sync2;
  logic [W-1:0] r_cnt;
  logic         r_smpA;
  logic         r_smpB;

  always_ff @(posedge i_clk) begin
    r_sync1 <= i_serial;
    r_sync2 <= r_sync1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_cntClear) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // First two votes are stored; the third is the live value at the decision count.
  always_ff @(posedge i_clk) begin
    if (r_cnt == CNT_SA) r_smpA <= r_sync2;
    if (r_cnt == CNT_SB) r_smpB <= r_sync2;
  end

  assign o_s         = r_sync2;
  assign o_bitStrobe = (r_cnt == CNT_DEC);
  assign o_bit       = (r_smpA & r_smpB) | (r_smpA & r_sync2) | (r_smpB & r_sync2);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, shift register and a valid/ready
// holding register with parity, framing, break and overrun reporting.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int clksPerBit = 234,
  parameter int dataBits   = 8,
  parameter int parityMode = 1,
  parameter int stopBits   = 1
) (
  input  logic                i_clkRx,
  input  logic                i_reset,
  input  logic                i_rxSerial,
  input  logic                i_rxReady,
  output logic                o_rxValid,
  output logic [dataBits-1:0] o_rxData,
  output logic                o_parityError,
  output logic                o_frameError,
  output logic                o_break,
  output logic                o_overrun
);

  localparam logic [3:0] LAST_DATA = 4'(dataBits - 1);
  localparam logic [3:0] LAST_STOP = 4'(stopBits - 1);

  logic                w_s;
  logic                w_strobe;
  logic                w_bit;
  logic                w_cntClear;
  logic                w_done;
  logic                w_frmErrNow;
  logic                w_brk;
  logic                w_parExp;
  logic                w_xfer;
  rx_state_t           r_state;
  rx_state_t           w_stateNext;
  logic [3:0]          r_bitIdx;
  logic [dataBits-1:0] r_shift;
  logic                r_parBit;
  logic                r_parErr;
  logic                r_frmErr;
  logic                r_valid;
  logic [dataBits-1:0] r_data;
  logic                r_perr;
  logic                r_ferr;
  logic                r_brk;
  logic                r_ovr;

  uart_rx_sampler #(
    .clksPerBit(clksPerBit)
  ) u_sampler (
    .i_clk      (i_clkRx),
    .i_reset    (i_reset),
    .i_serial   (i_rxSerial),
    .i_cntClear (w_cntClear),
    .o_s        (w_s),
    .o_bitStrobe(w_strobe),
    .o_bit      (w_bit)
  );

  assign w_parExp    = (parityMode == PARITY_ODD) ? ~^r_shift : ^r_shift;
  assign w_frmErrNow = r_frmErr | ~w_bit;
  assign w_brk       = (r_shift == '0) && ((parityMode == PARITY_NONE) || !r_parBit)
                       && w_frmErrNow;
  assign w_xfer      = r_valid & i_rxReady;

  always_ff @(posedge i_clkRx) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntClear  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_s) begin
          w_cntClear  = 1'b1;
          w_stateNext = ST_START;
        end
      end
      ST_START: begin
        if (w_strobe) w_stateNext = w_bit ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (w_strobe && (r_bitIdx == LAST_DATA))
          w_stateNext = (parityMode != PARITY_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (w_strobe) w_stateNext = ST_STOP;
      end
      ST_STOP: begin
        if (w_strobe && (r_bitIdx == LAST_STOP)) begin
          w_done      = 1'b1;
          w_stateNext = w_brk ? ST_BRKWAIT : ST_IDLE;
        end
      end
      ST_BRKWAIT: begin
        if (w_s) w_stateNext = ST_IDLE;
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clkRx) begin
    if (i_reset) begin
      r_bitIdx <= '0;
      r_parBit <= 1'b0;
      r_parErr <= 1'b0;
      r_frmErr <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_s) begin
            r_bitIdx <= '0;
            r_parBit <= 1'b0;
            r_parErr <= 1'b0;
            r_frmErr <= 1'b0;
          end
        end
        ST_DATA: begin
          if (w_strobe) r_bitIdx <= (r_bitIdx == LAST_DATA) ? 4'd0 : r_bitIdx + 4'd1;
        end
        ST_PARITY: begin
          if (w_strobe) begin
            r_parBit <= w_bit;
            r_parErr <= (w_bit != w_parExp);
          end
        end
        ST_STOP: begin
          if (w_strobe) begin
            r_frmErr <= w_frmErrNow;
            r_bitIdx <= r_bitIdx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Data bits arrive LSB first, so shift in from the top.
  always_ff @(posedge i_clkRx) begin
    if ((r_state == ST_DATA) && w_strobe) r_shift <= {w_bit, r_shift[dataBits-1:1]};
  end

  always_ff @(posedge i_clkRx) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_brk   <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_done) begin
      if (!r_valid || w_xfer) begin
        r_valid <= 1'b1;
        r_data  <= r_shift;
        r_perr  <= r_parErr;
        r_ferr  <= w_frmErrNow;
        r_brk   <= w_brk;
        if (w_xfer) r_ovr <= 1'b0;
      end else begin
        r_ovr <= 1'b1;
      end
    end else if (w_xfer) begin
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign o_rxValid     = r_valid;
  assign o_rxData      = r_data;
  assign o_parityError = r_perr;
  assign o_frameError  = r_ferr;
  assign o_break       = r_brk;
  assign o_overrun     = r_ovr;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8E1 and an 8O2 receiver at 16 clocks/bit.
module tb_uart_rx_param;

  localparam int CPB = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       br;
    logic       ov;
  } word_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ser_e = 1'b1;
  logic       ser_o = 1'b1;
  logic       rdy_e = 1'b1;
  logic       rdy_o = 1'b1;
  logic       vld_e, vld_o;
  logic [7:0] dat_e, dat_o;
  logic       pe_e, fe_e, br_e, ov_e;
  logic       pe_o, fe_o, br_o, ov_o;

  int n_checks = 0;
  int n_pass   = 0;
  int vcyc_e   = 0;
  word_t q_e[$];
  word_t q_o[$];

  always #5 clk = ~clk;

  uart_rx_param #(.clksPerBit(CPB), .dataBits(8), .parityMode(1), .stopBits(1)) dut_e (
    .i_clkRx(clk), .i_reset(rst), .i_rxSerial(ser_e), .i_rxReady(rdy_e),
    .o_rxValid(vld_e), .o_rxData(dat_e), .o_parityError(pe_e),
    .o_frameError(fe_e), .o_break(br_e), .o_overrun(ov_e));

  uart_rx_param #(.clksPerBit(CPB), .dataBits(8), .parityMode(2), .stopBits(2)) dut_o (
    .i_clkRx(clk), .i_reset(rst), .i_rxSerial(ser_o), .i_rxReady(rdy_o),
    .o_rxValid(vld_o), .o_rxData(dat_o), .o_parityError(pe_o),
    .o_frameError(fe_o), .o_break(br_o), .o_overrun(ov_o));

  always @(negedge clk) begin
    if (vld_e) vcyc_e <= vcyc_e + 1;
    if (vld_e && rdy_e) q_e.push_back('{dat_e, pe_e, fe_e, br_e, ov_e});
    if (vld_o && rdy_o) q_o.push_back('{dat_o, pe_o, fe_o, br_o, ov_o});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int sel, input logic [15:0] bits, input int n, input int spike);
    logic v;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < CPB; c++) begin
        v = bits[i];
        if (i == spike && c == 10) v = ~v;
        if (sel == 0) ser_e = v;
        else          ser_o = v;
        @(posedge clk);
        #1;
      end
    end
    ser_e = 1'b1;
    ser_o = 1'b1;
  endtask

  function automatic logic [15:0] mk_e(input logic [7:0] d, input logic p);
    return {5'b0, 1'b1, p, d, 1'b0};
  endfunction

  function automatic logic [15:0] mk_o(input logic [7:0] d, input logic p, input logic s2);
    return {4'b0, s2, 1'b1, p, d, 1'b0};
  endfunction

  task automatic pop_e(input string tag, output word_t w);
    chk({tag, "_present"}, q_e.size() > 0, 1);
    w = (q_e.size() > 0) ? q_e.pop_front() : '0;
  endtask

  task automatic pop_o(input string tag, output word_t w);
    chk({tag, "_present"}, q_o.size() > 0, 1);
    w = (q_o.size() > 0) ? q_o.pop_front() : '0;
  endtask

  initial begin
    word_t w;
    int    v0;

    idle(6);
    chk("rst_valid_e", vld_e, 0);
    chk("rst_data_e", dat_e, 0);
    chk("rst_flags_e", {pe_e, fe_e, br_e, ov_e}, 0);
    chk("rst_valid_o", vld_o, 0);
    rst = 1'b0;
    idle(4);

    // 8E1 0xA5, parity 0
    v0 = vcyc_e;
    send(0, mk_e(8'hA5, 1'b0), 11, -1);
    idle(4);
    pop_e("a5", w);
    chk("a5_data", w.d, 8'hA5);
    chk("a5_flags", {w.pe, w.fe, w.br, w.ov}, 0);
    chk("a5_valid_cycles", vcyc_e - v0, 1);
    chk("a5_valid_low", vld_e, 0);

    // 8O2 0x3C: good parity, bad parity, bad second stop
    send(1, mk_o(8'h3C, 1'b1, 1'b1), 12, -1);
    idle(4);
    pop_o("o_good", w);
    chk("o_good_data", w.d, 8'h3C);
    chk("o_good_flags", {w.pe, w.fe, w.br}, 0);
    send(1, mk_o(8'h3C, 1'b0, 1'b1), 12, -1);
    idle(4);
    pop_o("o_bad", w);
    chk("o_bad_data", w.d, 8'h3C);
    chk("o_bad_perr", w.pe, 1);
    chk("o_bad_ferr", w.fe, 0);
    send(1, mk_o(8'h3C, 1'b1, 1'b0), 12, -1);
    idle(4);
    pop_o("o_stop", w);
    chk("o_stop_ferr", w.fe, 1);
    chk("o_stop_perr", w.pe, 0);
    chk("o_stop_brk", w.br, 0);

    // overrun: three back-to-back frames with nobody reading
    rdy_e = 1'b0;
    send(0, mk_e(8'h11, 1'b0), 11, -1);
    send(0, mk_e(8'h22, 1'b0), 11, -1);
    send(0, mk_e(8'h33, 1'b0), 11, -1);
    idle(4);
    chk("ovr_valid", vld_e, 1);
    chk("ovr_data", dat_e, 8'h11);
    chk("ovr_flag", ov_e, 1);
    chk("ovr_perr", pe_e, 0);
    rdy_e = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ovr_valid_after", vld_e, 0);
    chk("ovr_flag_after", ov_e, 0);
    pop_e("ovr", w);
    chk("ovr_xfer_data", w.d, 8'h11);
    chk("ovr_xfer_ov", w.ov, 1);
    chk("ovr_queue_empty", q_e.size(), 0);
    idle(4);

    // break: line low for three frame times
    ser_e = 1'b0;
    idle(3 * 11 * CPB);
    chk("brk_count_low", q_e.size(), 1);
    ser_e = 1'b1;
    idle(2 * 11 * CPB);
    chk("brk_count", q_e.size(), 1);
    pop_e("brk", w);
    chk("brk_data", w.d, 0);
    chk("brk_flags", {w.br, w.fe, w.pe}, 3'b110);
    send(0, mk_e(8'h55, 1'b0), 11, -1);
    idle(4);
    pop_e("x55", w);
    chk("x55_data", w.d, 8'h55);
    chk("x55_flags", {w.pe, w.fe, w.br}, 0);

    // start glitch, then a frame with a one-clock spike in data bit 2
    ser_e = 1'b0;
    idle(4);
    ser_e = 1'b1;
    idle(3 * CPB);
    chk("glitch_ignored", q_e.size(), 0);
    send(0, mk_e(8'h0F, 1'b0), 11, 3);
    idle(4);
    pop_e("spike", w);
    chk("spike_data", w.d, 8'h0F);
    chk("spike_flags", {w.pe, w.fe, w.br}, 0);

    // reset mid-frame while a word is held
    rdy_e = 1'b0;
    send(0, mk_e(8'h42, 1'b0), 11, -1);
    idle(4);
    chk("hold_valid", vld_e, 1);
    chk("hold_data", dat_e, 8'h42);
    send(0, mk_e(8'hFF, 1'b0), 5, -1);
    ser_e = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid", vld_e, 0);
    chk("mid_rst_data", dat_e, 0);
    chk("mid_rst_flags", {pe_e, fe_e, br_e, ov_e}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_e = 1'b1;
    idle(2 * 11 * CPB);
    chk("mid_rst_no_word", q_e.size(), 0);
    send(0, mk_e(8'h81, 1'b0), 11, -1);
    idle(4);
    pop_e("x81", w);
    chk("x81_data", w.d, 8'h81);
    chk("x81_flags", {w.pe, w.fe, w.br, w.ov}, 0);
    chk("x81_queue_empty", q_e.size(), 0);
    chk("o_idle_queue", q_o.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
